// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame controller.
package spi_pkg;

  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ADDR   = 4'd1,
    RW     = 4'd2,
    DECIDE = 4'd3,
    LOAD   = 4'd4,
    READ   = 4'd5,
    RELOAD = 4'd6,
    WRITE  = 4'd7,
    COMMIT = 4'd8,
    DONE   = 4'd9
  } state_e;

  // Bit-counter width: enough bits to reach max(addr_w, data_w) - 1, at least 1.
  function automatic int unsigned cnt_width(input int unsigned addr_w,
                                            input int unsigned data_w);
    int unsigned m;
    m = (addr_w > data_w) ? addr_w : data_w;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Edge counter with synchronous clear, enable and terminal-count compare; holds at terminal.
module spi_bit_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic             tc_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_c_o = (cnt_q == tc_val_i);

  // Next count: clear wins, increment only below terminal so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_c_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI slave frame controller: address, R/W bit, then single or burst data words.
module spi_frame_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter bit          BURST_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_edge,
  input  logic cs,
  input  logic rw,
  output logic miso_buff,
  output logic addr_we,
  output logic addr_inc,
  output logic sr_we,
  output logic dm_we,
  output logic busy,
  output logic abort
);

  localparam int unsigned CNT_W = cnt_width(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] ADDR_TC = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_TC = CNT_W'(DATA_W - 1);

  state_e state_q;
  state_e state_d;

  logic counting_c;
  logic tc_c;
  logic last_edge_c;
  logic cnt_en_c;
  logic cnt_clr_c;
  logic [CNT_W-1:0] tc_val_c;

  logic miso_buff_d;
  logic addr_we_d;
  logic addr_inc_d;
  logic sr_we_d;
  logic dm_we_d;
  logic busy_d;
  logic abort_d;

  // Counter control: count edges only in shifting states; zero on every state entry.
  always_comb begin
    counting_c  = (state_q == ADDR) || (state_q == READ) || (state_q == WRITE);
    tc_val_c    = (state_q == ADDR) ? ADDR_TC : DATA_TC;
    cnt_en_c    = sclk_edge && counting_c;
    last_edge_c = cnt_en_c && tc_c;
    cnt_clr_c   = cs || !counting_c || last_edge_c;
  end

  spi_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cnt_clr_c),
    .en_i     (cnt_en_c),
    .tc_val_i (tc_val_c),
    .tc_c_o   (tc_c)
  );

  // Next-state logic; a deselect returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (cs) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ADDR;
        ADDR:    if (last_edge_c) state_d = RW;
        RW:      if (sclk_edge) state_d = DECIDE;
        DECIDE:  state_d = rw ? LOAD : WRITE;
        LOAD:    state_d = READ;
        READ:    if (last_edge_c) state_d = BURST_EN ? RELOAD : DONE;
        RELOAD:  state_d = LOAD;
        WRITE:   if (last_edge_c) state_d = COMMIT;
        COMMIT:  state_d = BURST_EN ? WRITE : DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode of the upcoming state so registered outputs line up with the state register.
  always_comb begin
    busy_d      = (state_d != IDLE);
    addr_we_d   = (state_d == ADDR);
    addr_inc_d  = (state_d == RELOAD) || (BURST_EN && (state_d == COMMIT));
    sr_we_d     = (state_d == LOAD);
    dm_we_d     = (state_d == COMMIT);
    // MISO stays driven through the reload of a burst read, but not on the first load.
    miso_buff_d = (state_d == READ) || (state_d == RELOAD) ||
                  ((state_d == LOAD) && (state_q == RELOAD));
    abort_d     = cs && (state_q != IDLE) && (state_q != DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      miso_buff <= 1'b0;
      addr_we   <= 1'b0;
      addr_inc  <= 1'b0;
      sr_we     <= 1'b0;
      dm_we     <= 1'b0;
      busy      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state_q   <= state_d;
      miso_buff <= miso_buff_d;
      addr_we   <= addr_we_d;
      addr_inc  <= addr_inc_d;
      sr_we     <= sr_we_d;
      dm_we     <= dm_we_d;
      busy      <= busy_d;
      abort     <= abort_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: one single-word instance and one burst instance.
module tb_spi_frame_ctrl;

  // Output vector order: {busy, addr_we, addr_inc, sr_we, dm_we, miso_buff, abort}
  localparam logic [6:0] O_IDLE    = 7'b0000000;
  localparam logic [6:0] O_ADDR    = 7'b1100000;
  localparam logic [6:0] O_BUSY    = 7'b1000000;
  localparam logic [6:0] O_LOAD    = 7'b1001000;
  localparam logic [6:0] O_LOAD_B  = 7'b1001010;
  localparam logic [6:0] O_READ    = 7'b1000010;
  localparam logic [6:0] O_RELOAD  = 7'b1010010;
  localparam logic [6:0] O_COMMIT0 = 7'b1000100;
  localparam logic [6:0] O_COMMIT1 = 7'b1010100;
  localparam logic [6:0] O_ABORT   = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk_edge;
  logic cs0, cs1;
  logic rw;
  logic miso0, aw0, ai0, sr0, dm0, busy0, ab0;
  logic miso1, aw1, ai1, sr1, dm1, busy1, ab1;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  spi_frame_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST_EN(1'b0)) u_single (
    .clk(clk), .rst_n(rst_n), .sclk_edge(sclk_edge), .cs(cs0), .rw(rw),
    .miso_buff(miso0), .addr_we(aw0), .addr_inc(ai0), .sr_we(sr0),
    .dm_we(dm0), .busy(busy0), .abort(ab0)
  );

  spi_frame_ctrl #(.ADDR_W(7), .DATA_W(8), .BURST_EN(1'b1)) u_burst (
    .clk(clk), .rst_n(rst_n), .sclk_edge(sclk_edge), .cs(cs1), .rw(rw),
    .miso_buff(miso1), .addr_we(aw1), .addr_inc(ai1), .sr_we(sr1),
    .dm_we(dm1), .busy(busy1), .abort(ab1)
  );

  function automatic logic [6:0] outs(input bit sel);
    return sel ? {busy1, aw1, ai1, sr1, dm1, miso1, ab1}
               : {busy0, aw0, ai0, sr0, dm0, miso0, ab0};
  endfunction

  task automatic chk(input string tag, input bit sel, input logic [6:0] exp);
    logic [6:0] obs;
    obs = outs(sel);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut=%0d observed=%b expected=%b", tag, sel, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) cyc();
  endtask

  task automatic edge_();
    sclk_edge = 1'b1;
    cyc();
    sclk_edge = 1'b0;
  endtask

  task automatic set_cs(input bit sel, input logic v);
    if (sel) cs1 = v;
    else     cs0 = v;
  endtask

  // Select, 7 address edges, then the R/W edge; ends one clk after the R/W edge (DECIDE).
  task automatic addr_phase(input bit sel, input logic rwbit);
    set_cs(sel, 1'b0);
    cyc();
    chk("cs_fall_addr_we", sel, O_ADDR);
    gap(3);
    for (int i = 0; i < 7; i++) begin
      edge_();
      if (i < 6) chk("addr_edge", sel, O_ADDR);
      else       chk("addr_last_edge", sel, O_BUSY);
      gap(7);
    end
    rw = rwbit;
    edge_();
    chk("rw_edge_decide", sel, O_BUSY);
  endtask

  task automatic read_frame(input bit sel, input int words);
    addr_phase(sel, 1'b1);
    cyc();
    chk("read_load", sel, O_LOAD);
    cyc();
    chk("read_miso_on", sel, O_READ);
    gap(5);
    for (int w = 0; w < words; w++) begin
      for (int j = 0; j < 8; j++) begin
        edge_();
        if (j < 7) begin
          chk("read_data_edge", sel, O_READ);
          gap(7);
        end else if (sel) begin
          chk("burst_reload", sel, O_RELOAD);
          cyc();
          chk("burst_load_miso", sel, O_LOAD_B);
          cyc();
          chk("burst_read_again", sel, O_READ);
          gap(5);
        end else begin
          chk("read_done", sel, O_BUSY);
          gap(7);
        end
      end
    end
    if (sel) begin
      set_cs(sel, 1'b1);
      cyc();
      chk("burst_read_end_abort", sel, O_ABORT);
      cyc();
      chk("burst_read_idle", sel, O_IDLE);
    end else begin
      edge_();
      chk("done_ignores_edge", sel, O_BUSY);
      gap(3);
      set_cs(sel, 1'b1);
      cyc();
      chk("read_deselect_idle", sel, O_IDLE);
    end
  endtask

  task automatic write_frame(input bit sel, input int words);
    addr_phase(sel, 1'b0);
    cyc();
    chk("write_enter", sel, O_BUSY);
    gap(6);
    for (int w = 0; w < words; w++) begin
      for (int j = 0; j < 8; j++) begin
        edge_();
        if (j < 7) begin
          chk("write_data_edge", sel, O_BUSY);
          gap(7);
        end else begin
          chk("write_commit", sel, sel ? O_COMMIT1 : O_COMMIT0);
          cyc();
          chk("write_after_commit", sel, O_BUSY);
          gap(6);
        end
      end
    end
    if (sel) begin
      set_cs(sel, 1'b1);
      cyc();
      chk("burst_write_end_abort", sel, O_ABORT);
      cyc();
      chk("burst_write_idle", sel, O_IDLE);
    end else begin
      edge_();
      chk("done_ignores_edge", sel, O_BUSY);
      gap(3);
      set_cs(sel, 1'b1);
      cyc();
      chk("write_deselect_idle", sel, O_IDLE);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    sclk_edge = 1'b0;
    cs0       = 1'b1;
    cs1       = 1'b1;
    rw        = 1'b0;
    gap(3);
    chk("reset_single", 1'b0, O_IDLE);
    chk("reset_burst", 1'b1, O_IDLE);
    rst_n = 1'b1;
    gap(2);
    chk("idle_deselected", 1'b0, O_IDLE);

    // Single-word write and read.
    write_frame(1'b0, 1);
    gap(4);
    read_frame(1'b0, 1);
    gap(4);

    // Burst write of three words and burst read of two words.
    write_frame(1'b1, 3);
    gap(4);
    read_frame(1'b1, 2);
    gap(4);

    // Deselect after data edge 4 of a write.
    addr_phase(1'b0, 1'b0);
    cyc();
    chk("abort_write_enter", 1'b0, O_BUSY);
    gap(6);
    for (int j = 0; j < 4; j++) begin
      edge_();
      chk("abort_write_edge", 1'b0, O_BUSY);
      if (j < 3) gap(7);
    end
    gap(3);
    set_cs(1'b0, 1'b1);
    cyc();
    chk("abort_pulse", 1'b0, O_ABORT);
    cyc();
    chk("abort_idle", 1'b0, O_IDLE);
    gap(4);

    // Reset asserted during READ, then a clean single read.
    addr_phase(1'b0, 1'b1);
    cyc();
    chk("rst_read_load", 1'b0, O_LOAD);
    cyc();
    chk("rst_read_miso", 1'b0, O_READ);
    gap(5);
    edge_();
    gap(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_read", 1'b0, O_IDLE);
    set_cs(1'b0, 1'b1);
    cyc();
    cyc();
    chk("reset_held_no_abort", 1'b0, O_IDLE);
    rst_n = 1'b1;
    gap(2);
    read_frame(1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
